// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, store-data port, write port and claim port.
// The master drives addresses and strobes; the slave returns read data, busy flags and the count.
interface regfile_scoreboard_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
);
    logic [AddrSize-1:0] read_reg_addr1;
    logic [AddrSize-1:0] read_reg_addr2;
    logic                do_reg_fetch;
    logic [DataSize-1:0] read_reg_data1;
    logic [DataSize-1:0] read_reg_data2;
    logic                read_busy1;
    logic                read_busy2;
    logic [AddrSize-1:0] store_addr;
    logic [DataSize-1:0] mem_write_data;
    logic [AddrSize-1:0] write_address;
    logic [DataSize-1:0] write_data;
    logic                enable_reg_write;
    logic                do_reg_write;
    logic [AddrSize-1:0] claim_addr;
    logic                do_claim;
    logic [AddrSize:0]   busy_count;

    modport master (
        output read_reg_addr1, read_reg_addr2, do_reg_fetch, store_addr,
               write_address, write_data, enable_reg_write, do_reg_write,
               claim_addr, do_claim,
        input  read_reg_data1, read_reg_data2, read_busy1, read_busy2,
               mem_write_data, busy_count
    );

    modport slave (
        input  read_reg_addr1, read_reg_addr2, do_reg_fetch, store_addr,
               write_address, write_data, enable_reg_write, do_reg_write,
               claim_addr, do_claim,
        output read_reg_data1, read_reg_data2, read_busy1, read_busy2,
               mem_write_data, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports (write bypass), a combinational store-data port,
// and a per-entry pending (scoreboard) bit set by claims and cleared by committed writes.
module regfile_scoreboard #(
    parameter int DataSize    = 32,
    parameter int AddrSize    = 5,
    parameter int ZeroReg     = 1,
    parameter int ClearOnIdle = 1
) (
    input logic                clock,
    input logic                reset,
    regfile_scoreboard_if.slave bus
);
    localparam int Depth = 1 << AddrSize;

    logic [DataSize-1:0] regs [Depth];
    logic [Depth-1:0]    pending;
    logic [Depth-1:0]    pending_nxt;
    logic                wr_commit;
    logic                claim_ok;
    logic [DataSize-1:0] rd1_nxt;
    logic [DataSize-1:0] rd2_nxt;

    function automatic logic [AddrSize:0] popcount(input logic [Depth-1:0] v);
        logic [AddrSize:0] c;
        c = '0;
        for (int i = 0; i < Depth; i++) begin
            c = c + {{AddrSize{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        wr_commit = bus.do_reg_write && bus.enable_reg_write &&
                    !((ZeroReg != 0) && (bus.write_address == '0));
        claim_ok  = bus.do_claim && !((ZeroReg != 0) && (bus.claim_addr == '0));

        // Claim is applied after the write clear so a same-edge new producer keeps the bit set.
        pending_nxt = pending;
        if (wr_commit) pending_nxt[bus.write_address] = 1'b0;
        if (claim_ok)  pending_nxt[bus.claim_addr]    = 1'b1;

        if ((ZeroReg != 0) && (bus.read_reg_addr1 == '0))
            rd1_nxt = '0;
        else if (wr_commit && (bus.write_address == bus.read_reg_addr1))
            rd1_nxt = bus.write_data;
        else
            rd1_nxt = regs[bus.read_reg_addr1];

        if ((ZeroReg != 0) && (bus.read_reg_addr2 == '0))
            rd2_nxt = '0;
        else if (wr_commit && (bus.write_address == bus.read_reg_addr2))
            rd2_nxt = bus.write_data;
        else
            rd2_nxt = regs[bus.read_reg_addr2];
    end

    // Store-data path deliberately sees only committed contents, never the in-flight write.
    assign bus.mem_write_data = ((ZeroReg != 0) && (bus.store_addr == '0)) ? '0
                                                                           : regs[bus.store_addr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) regs[i] <= '0;
            pending            <= '0;
            bus.busy_count     <= '0;
            bus.read_reg_data1 <= '0;
            bus.read_reg_data2 <= '0;
            bus.read_busy1     <= 1'b0;
            bus.read_busy2     <= 1'b0;
        end else begin
            if (wr_commit) regs[bus.write_address] <= bus.write_data;
            pending        <= pending_nxt;
            bus.busy_count <= popcount(pending_nxt);

            if (bus.do_reg_fetch) begin
                bus.read_reg_data1 <= rd1_nxt;
                bus.read_reg_data2 <= rd2_nxt;
                bus.read_busy1     <= pending_nxt[bus.read_reg_addr1];
                bus.read_busy2     <= pending_nxt[bus.read_reg_addr2];
            end else if (ClearOnIdle != 0) begin
                bus.read_reg_data1 <= '0;
                bus.read_reg_data2 <= '0;
                bus.read_busy1     <= 1'b0;
                bus.read_busy2     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table for single-edge behaviour plus
// hand sequences for bypass timing, idle clear/hold, saturation of claims and async reset.
module tb_regfile_scoreboard;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_scoreboard_if #(.DataSize(32), .AddrSize(5)) bus ();
    regfile_scoreboard_if #(.DataSize(32), .AddrSize(5)) bus_h ();

    regfile_scoreboard #(.DataSize(32), .AddrSize(5), .ZeroReg(1), .ClearOnIdle(1)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    regfile_scoreboard #(.DataSize(32), .AddrSize(5), .ZeroReg(1), .ClearOnIdle(0)) dut_h (
        .clock(clock), .reset(reset), .bus(bus_h));

    // The hold-variant instance sees exactly the same stimulus.
    assign bus_h.read_reg_addr1   = bus.read_reg_addr1;
    assign bus_h.read_reg_addr2   = bus.read_reg_addr2;
    assign bus_h.do_reg_fetch     = bus.do_reg_fetch;
    assign bus_h.store_addr       = bus.store_addr;
    assign bus_h.write_address    = bus.write_address;
    assign bus_h.write_data       = bus.write_data;
    assign bus_h.enable_reg_write = bus.enable_reg_write;
    assign bus_h.do_reg_write     = bus.do_reg_write;
    assign bus_h.claim_addr       = bus.claim_addr;
    assign bus_h.do_claim         = bus.do_claim;

    typedef struct {
        logic        wr;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        f;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        cl;
        logic [4:0]  ca;
        logic [4:0]  sa;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
        logic [31:0] mw;
    } vec_t;

    vec_t tbl[13];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic vec_t mk(input logic wr, input logic en, input logic [4:0] wa,
                                input logic [31:0] wd, input logic f, input logic [4:0] a1,
                                input logic [4:0] a2, input logic cl, input logic [4:0] ca,
                                input logic [4:0] sa, input logic [31:0] d1,
                                input logic [31:0] d2, input logic b1, input logic b2,
                                input logic [5:0] cnt, input logic [31:0] mw);
        vec_t v;
        v.wr = wr; v.en = en; v.wa = wa; v.wd = wd; v.f = f; v.a1 = a1; v.a2 = a2;
        v.cl = cl; v.ca = ca; v.sa = sa; v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2;
        v.cnt = cnt; v.mw = mw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.do_reg_write     = v.wr;
        bus.enable_reg_write = v.en;
        bus.write_address    = v.wa;
        bus.write_data       = v.wd;
        bus.do_reg_fetch     = v.f;
        bus.read_reg_addr1   = v.a1;
        bus.read_reg_addr2   = v.a2;
        bus.do_claim         = v.cl;
        bus.claim_addr       = v.ca;
        bus.store_addr       = v.sa;
    endtask

    task automatic idle();
        bus.do_reg_write     = 1'b0;
        bus.enable_reg_write = 1'b0;
        bus.write_address    = 5'd0;
        bus.write_data       = 32'd0;
        bus.do_reg_fetch     = 1'b0;
        bus.read_reg_addr1   = 5'd0;
        bus.read_reg_addr2   = 5'd0;
        bus.do_claim         = 1'b0;
        bus.claim_addr       = 5'd0;
        bus.store_addr       = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".d1"},  bus.read_reg_data1,           32'd0);
        chk({nm, ".d2"},  bus.read_reg_data2,           32'd0);
        chk({nm, ".b1"},  {31'd0, bus.read_busy1},      32'd0);
        chk({nm, ".b2"},  {31'd0, bus.read_busy2},      32'd0);
        chk({nm, ".cnt"}, {26'd0, bus.busy_count},      32'd0);
        chk({nm, ".h_d1"}, bus_h.read_reg_data1,        32'd0);
        chk({nm, ".h_b2"}, {31'd0, bus_h.read_busy2},   32'd0);
        chk({nm, ".h_cnt"}, {26'd0, bus_h.busy_count},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             wr    en    wa     wd            f     a1     a2     cl    ca     sa     d1            d2            b1    b2    cnt    mw
        tbl[0]  = mk(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0, 32'hDEADBEEF);
        tbl[1]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0, 32'hDEADBEEF);
        tbl[3]  = mk(1'b1, 1'b0, 5'd5, 32'h11111111, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0, 32'hDEADBEEF);
        tbl[4]  = mk(1'b0, 1'b1, 5'd6, 32'h22222222, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 5'd6, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0, 32'h0);
        tbl[5]  = mk(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 5'd3, 32'h0,        32'h0,        1'b1, 1'b0, 6'd1, 32'h0);
        tbl[7]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd4, 1'b1, 5'd4, 5'd0, 32'h0,        32'h0,        1'b1, 1'b1, 6'd2, 32'h0);
        tbl[8]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd2, 32'h0);
        tbl[9]  = mk(1'b1, 1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 5'd3, 32'hAAAA0003, 32'h0,        1'b0, 1'b1, 6'd1, 32'hAAAA0003);
        tbl[10] = mk(1'b1, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 5'd4, 1'b1, 5'd4, 5'd4, 32'hAAAA0003, 32'h44444444, 1'b0, 1'b1, 6'd1, 32'h44444444);
        tbl[11] = mk(1'b1, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd4, 1'b0, 5'd0, 5'd9, 32'h00000099, 32'h44444444, 1'b0, 1'b1, 6'd1, 32'h00000099);
        tbl[12] = mk(1'b1, 1'b1, 5'd4, 32'h00000055, 1'b1, 5'd9, 5'd4, 1'b0, 5'd0, 5'd4, 32'h00000099, 32'h00000055, 1'b0, 1'b0, 6'd0, 32'h00000055);

        // Reset asserted from time zero, checked before and after the first edge.
        reset = 1'b0;
        idle();
        #1;
        chk_all_zero("rst0");
        tick();
        chk_all_zero("rst1");
        #2 reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            tick();
            chk($sformatf("v%0d.d1", i),  bus.read_reg_data1,      tbl[i].d1);
            chk($sformatf("v%0d.d2", i),  bus.read_reg_data2,      tbl[i].d2);
            chk($sformatf("v%0d.b1", i),  {31'd0, bus.read_busy1}, {31'd0, tbl[i].b1});
            chk($sformatf("v%0d.b2", i),  {31'd0, bus.read_busy2}, {31'd0, tbl[i].b2});
            chk($sformatf("v%0d.cnt", i), {26'd0, bus.busy_count}, {26'd0, tbl[i].cnt});
            chk($sformatf("v%0d.mw", i),  bus.mem_write_data,      tbl[i].mw);
        end

        // Same-edge write and fetch: fetch bypasses, store port shows the old value until the edge.
        idle();
        bus.do_reg_write = 1'b1; bus.enable_reg_write = 1'b1;
        bus.write_address = 5'd7; bus.write_data = 32'h0BADF00D;
        tick();
        bus.write_data = 32'h12345678;
        bus.do_reg_fetch = 1'b1; bus.read_reg_addr2 = 5'd7; bus.store_addr = 5'd7;
        #1;
        chk("byp.mw_before", bus.mem_write_data, 32'h0BADF00D);
        tick();
        chk("byp.d2", bus.read_reg_data2, 32'h12345678);
        chk("byp.b2", {31'd0, bus.read_busy2}, 32'd0);
        chk("byp.mw_after", bus.mem_write_data, 32'h12345678);

        // Fetch followed by an idle edge: cleared in one variant, held in the other.
        idle();
        bus.do_reg_fetch = 1'b1; bus.read_reg_addr1 = 5'd5; bus.read_reg_addr2 = 5'd3;
        bus.do_claim = 1'b1; bus.claim_addr = 5'd3;
        tick();
        chk("idle.f_d1", bus.read_reg_data1, 32'hDEADBEEF);
        chk("idle.f_d2", bus.read_reg_data2, 32'hAAAA0003);
        chk("idle.f_b2", {31'd0, bus.read_busy2}, 32'd1);
        chk("idle.f_h_d1", bus_h.read_reg_data1, 32'hDEADBEEF);
        idle();
        tick();
        chk("idle.c_d1", bus.read_reg_data1, 32'd0);
        chk("idle.c_d2", bus.read_reg_data2, 32'd0);
        chk("idle.c_b2", {31'd0, bus.read_busy2}, 32'd0);
        chk("idle.h_d1", bus_h.read_reg_data1, 32'hDEADBEEF);
        chk("idle.h_d2", bus_h.read_reg_data2, 32'hAAAA0003);
        chk("idle.h_b2", {31'd0, bus_h.read_busy2}, 32'd1);
        chk("idle.cnt", {26'd0, bus.busy_count}, 32'd1);

        // Claim every entry including r0; count tops out at 31.
        for (int a = 0; a < 32; a++) begin
            idle();
            bus.do_claim = 1'b1;
            bus.claim_addr = 5'(a);
            tick();
        end
        chk("full.cnt", {26'd0, bus.busy_count}, 32'd31);
        idle();
        bus.do_reg_fetch = 1'b1; bus.read_reg_addr1 = 5'd31; bus.read_reg_addr2 = 5'd0;
        bus.store_addr = 5'd5;
        tick();
        chk("full.b1", {31'd0, bus.read_busy1}, 32'd1);
        chk("full.b2_r0", {31'd0, bus.read_busy2}, 32'd0);
        chk("full.cnt2", {26'd0, bus.busy_count}, 32'd31);

        // Mid-cycle reset clears everything before the next edge; activity under reset is dropped.
        #3 reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst.mw", bus.mem_write_data, 32'd0);
        bus.do_reg_write = 1'b1; bus.enable_reg_write = 1'b1;
        bus.write_address = 5'd5; bus.write_data = 32'h77777777;
        bus.do_claim = 1'b1; bus.claim_addr = 5'd5;
        tick();
        chk_all_zero("inrst");
        chk("inrst.mw", bus.mem_write_data, 32'd0);
        #2 reset = 1'b1;
        idle();
        bus.do_reg_fetch = 1'b1; bus.read_reg_addr1 = 5'd5; bus.store_addr = 5'd5;
        tick();
        chk("post.d1", bus.read_reg_data1, 32'd0);
        chk("post.b1", {31'd0, bus.read_busy1}, 32'd0);
        chk("post.cnt", {26'd0, bus.busy_count}, 32'd0);
        chk("post.mw", bus.mem_write_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DataSize, default 32, register width in bits.
REQ-002 SHALL provide parameter AddrSize, default 5, address width; depth = 2^AddrSize entries.
REQ-003 SHALL provide parameter ZeroReg, default 1, 1 = entry 0 hardwired to zero.
REQ-004 SHALL provide parameter ClearOnIdle, default 1, 1 = read outputs zeroed on cycles without fetch, 0 = held.
REQ-005 SHALL provide port clock  input  1  sole clock, all state on rising edge.
REQ-006 SHALL provide port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL provide ports read_reg_addr1, read_reg_addr2  input  AddrSize  read-port addresses.
REQ-008 SHALL provide port do_reg_fetch  input  1  read-port sample strobe.
REQ-009 SHALL provide ports read_reg_data1, read_reg_data2  output  DataSize  registered read data.
REQ-010 SHALL provide ports read_busy1, read_busy2  output  1  registered pending-write flag of the sampled address.
REQ-011 SHALL provide port store_addr  input  AddrSize  store-data read address.
REQ-012 SHALL provide port mem_write_data  output  DataSize  combinational contents of entry store_addr.
REQ-013 SHALL provide ports write_address  input  AddrSize, write_data  input  DataSize  write port.
REQ-014 SHALL provide ports enable_reg_write, do_reg_write  input  1  write commits only when both are 1.
REQ-015 SHALL provide ports claim_addr  input  AddrSize, do_claim  input  1  reserve an entry as pending.
REQ-016 SHALL provide port busy_count  output  AddrSize+1  registered number of pending entries.

Function
REQ-017 SHALL commit write_data to entry write_address on a rising edge where do_reg_write and enable_reg_write are both 1, independent of do_reg_fetch.
REQ-018 SHALL, with ZeroReg=1, ignore writes and claims to address 0; entry 0 reads as zero and never reports busy.
REQ-019 SHALL, on a rising edge with do_reg_fetch=1, load read_reg_dataN with entry read_reg_addrN, one-cycle latency.
REQ-020 SHALL bypass: if a write commits in the same edge to the address being fetched, read_reg_dataN loads write_data, not stale contents.
REQ-021 SHALL load read_busyN with the pending bit of read_reg_addrN as it will be after that edge (write clear and claim set applied).
REQ-022 SHALL, on edges with do_reg_fetch=0, load zero into read data and busy outputs when ClearOnIdle=1, hold them when ClearOnIdle=0.
REQ-023 SHALL keep one pending bit per entry: do_claim sets bit claim_addr; a committed write clears bit write_address.
REQ-024 SHALL, when claim and write target the same address in one edge, commit the data and leave the bit set (new producer wins).
REQ-025 SHALL leave state unchanged when claiming an already-pending entry, and when writing a non-pending entry (data still commits).
REQ-026 SHALL update busy_count each edge to the population of pending bits after that edge; maximum 2^AddrSize (or 2^AddrSize-1 with ZeroReg=1), no wrap.
REQ-027 SHALL drive mem_write_data combinationally from stored contents without write bypass; zero for address 0 when ZeroReg=1.

Reset
REQ-028 SHALL, while reset=0, immediately force all entries, pending bits, read_reg_data1/2, read_busy1/2 and busy_count to zero.
REQ-029 SHALL discard any write, claim or fetch coinciding with reset assertion; normal operation resumes on the first rising edge with reset=1.

Verification
REQ-030 SHALL cover: reset, write 0xDEADBEEF to r5, next cycle fetch addr1=5 -> read_reg_data1=0xDEADBEEF one cycle later, read_busy1=0.
REQ-031 SHALL cover: same-edge write 0x12345678 to r7 and fetch addr2=7 -> read_reg_data2=0x12345678 (bypass), mem_write_data with store_addr=7 shows old value until the edge.
REQ-032 SHALL cover: write 0xFFFFFFFF to r0 with ZeroReg=1, claim r0 -> fetch r0 gives 0, read_busy=0, busy_count=0.
REQ-033 SHALL cover: claim r3, r4, r3 -> busy_count=2; write r3 -> busy_count=1; claim+write r4 same edge -> busy_count stays 1, r4 busy.
REQ-034 SHALL cover: ClearOnIdle=1 fetch then idle cycle -> outputs 0; ClearOnIdle=0 same sequence -> outputs held.
REQ-035 SHALL cover: claim all 31 nonzero entries -> busy_count=31; pull reset low mid-cycle -> all outputs 0 before next edge.
